// File: rtl/key_schedule.sv
// AES-128 key schedule: streams round keys 0..10 over a valid/ready handshake,
// one key per accepted cycle, with the next key computed combinationally.
module key_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_ready,
   output logic [127:0] round_key,
   output logic [3:0]   round_idx,
   output logic         key_valid,
   output logic         busy,
   output logic         done
);

   localparam logic [0:0] StIdle   = 1'b0;
   localparam logic [0:0] StActive = 1'b1;

   localparam logic [3:0] LastRound = 4'd10;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SboxTable = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [0:0]   state_q, state_d;
   logic [127:0] round_key_q, round_key_d;
   logic [3:0]   round_idx_q, round_idx_d;
   logic         key_valid_q, key_valid_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_w, sub_w, t_w;
   logic [31:0]  n0, n1, n2, n3;

   // Entry b sits at bit offset (255-b)*8, and 255-b is ~b for a byte.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SboxTable[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Next round key derived from the currently presented one.
   always_comb begin
      w0    = round_key_q[127:96];
      w1    = round_key_q[95:64];
      w2    = round_key_q[63:32];
      w3    = round_key_q[31:0];
      rot_w = {w3[23:0], w3[31:24]};
      sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      t_w   = sub_w ^ {rcon(round_idx_q + 4'd1), 24'h0};
      n0    = w0 ^ t_w;
      n1    = w1 ^ n0;
      n2    = w2 ^ n1;
      n3    = w3 ^ n2;
   end

   // Handshake FSM: load on start, advance on transfer, finish after round 10.
   always_comb begin
      state_d     = state_q;
      round_key_d = round_key_q;
      round_idx_d = round_idx_q;
      key_valid_d = key_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               round_key_d = key_in;
               round_idx_d = 4'd0;
               key_valid_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = StActive;
            end
         end
         default: begin
            if (key_ready) begin
               if (round_idx_q == LastRound) begin
                  // Key and index are left as-is so the final key stays observable.
                  key_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  state_d     = StIdle;
               end else begin
                  round_key_d = {n0, n1, n2, n3};
                  round_idx_d = round_idx_q + 4'd1;
               end
            end
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         round_key_q <= '0;
         round_idx_q <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_key_q <= round_key_d;
         round_idx_q <= round_idx_d;
         key_valid_q <= key_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign round_key = round_key_q;
   assign round_idx = round_idx_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule using FIPS-197 and all-zero key vectors.
module tb_key_schedule;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         key_ready;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         busy;
   logic         done;

   int errors;
   int checks;

   logic [127:0] fips_keys [0:10];
   logic [127:0] exp_keys  [0:10];

   key_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .key_in    (key_in),
      .key_ready (key_ready),
      .round_key (round_key),
      .round_idx (round_idx),
      .key_valid (key_valid),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] k);
      start  = 1'b1;
      key_in = k;
      step();
      start  = 1'b0;
   endtask

   task automatic load_fips();
      for (int i = 0; i <= 10; i++) exp_keys[i] = fips_keys[i];
   endtask

   task automatic load_zero();
      for (int i = 0; i <= 10; i++) exp_keys[i] = 128'h0;
      exp_keys[1]  = 128'h62636363626363636263636362636363;
      exp_keys[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   endtask

   // Walk rounds 0..10 from the currently presented key, then check the done cycle.
   // Only rounds whose expected value is nonzero in exp_keys (or round 0) are compared by key.
   task automatic follow(input string tag, input bit rand_ready, input int busy_start_at,
                         input bit full_table);
      int e;
      int n;
      logic kr;
      e = 0;
      n = 0;
      while (e <= 10 && n < 300) begin
         check({tag, " valid"}, 128'(key_valid), 128'(1));
         check({tag, " idx"}, 128'(round_idx), 128'(e));
         if (full_table || e == 0 || e == 1 || e == 10)
            check({tag, " key"}, round_key, exp_keys[e]);
         kr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         key_ready = kr;
         if (e == busy_start_at) begin
            start  = 1'b1;
            key_in = 128'h00112233445566778899aabbccddeeff;
         end
         step();
         start = 1'b0;
         n++;
         if (kr) e++;
      end
      if (n >= 300) check({tag, " timeout"}, 128'(n), 128'(0));
      check({tag, " done"}, 128'(done), 128'(1));
      check({tag, " valid end"}, 128'(key_valid), 128'(0));
      check({tag, " busy end"}, 128'(busy), 128'(0));
      check({tag, " idx held"}, 128'(round_idx), 128'(10));
      check({tag, " key held"}, round_key, exp_keys[10]);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      key_in    = '0;
      key_ready = 1'b0;

      fips_keys[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      // Reset state
      step();
      step();
      check("rst key", round_key, 128'h0);
      check("rst idx", 128'(round_idx), 128'(0));
      check("rst valid", 128'(key_valid), 128'(0));
      check("rst busy", 128'(busy), 128'(0));
      check("rst done", 128'(done), 128'(0));
      rst = 1'b0;

      // FIPS-197 vector, continuous ready
      load_fips();
      key_ready = 1'b1;
      do_start(fips_keys[0]);
      follow("fips", 1'b0, -1, 1'b1);
      step();
      check("fips done pulse", 128'(done), 128'(0));
      check("fips idle valid", 128'(key_valid), 128'(0));

      // All-zero key, then back-to-back restart on the done cycle
      load_zero();
      do_start(128'h0);
      follow("zero", 1'b0, -1, 1'b0);
      load_fips();
      do_start(fips_keys[0]);
      check("b2b done clr", 128'(done), 128'(0));
      follow("b2b", 1'b0, -1, 1'b1);

      // Random backpressure
      step();
      key_ready = 1'b0;
      do_start(fips_keys[0]);
      follow("bp", 1'b1, -1, 1'b1);

      // Start while busy at round 4 must be ignored
      step();
      key_ready = 1'b1;
      do_start(fips_keys[0]);
      follow("busystart", 1'b0, 4, 1'b1);

      // Reset at round 6 aborts without done
      step();
      key_ready = 1'b1;
      do_start(fips_keys[0]);
      repeat (6) step();
      check("mid idx", 128'(round_idx), 128'(6));
      check("mid key", round_key, fips_keys[6]);
      rst = 1'b1;
      #1;
      check("arst key", round_key, 128'h0);
      check("arst idx", 128'(round_idx), 128'(0));
      check("arst valid", 128'(key_valid), 128'(0));
      check("arst busy", 128'(busy), 128'(0));
      check("arst done", 128'(done), 128'(0));
      step();
      check("arst done2", 128'(done), 128'(0));
      rst = 1'b0;
      load_zero();
      do_start(128'h0);
      check("post rst done", 128'(done), 128'(0));
      follow("postrst", 1'b0, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
